// File: rtl/layer_compositor.sv
// layer_compositor: two-stage registered priority compositor with frame-latched enable/blink masks
module layer_compositor #(
  parameter int N_LAYERS = 4,
  parameter int COLOR_W = 3,
  parameter int BLINK_DIV = 30,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_LAYERS*COLOR_W-1:0]       layer_color_i,
  input  logic                              hsync_i,
  input  logic                              vsync_i,
  input  logic                              active_i,
  input  logic [N_LAYERS-1:0]               layer_en_i,
  input  logic [N_LAYERS-1:0]               blink_en_i,
  output logic [COLOR_W-1:0]                color_o,
  output logic                              hsync_o,
  output logic                              vsync_o,
  output logic                              active_o,
  output logic [$clog2(N_LAYERS+1)-1:0]     top_layer_o,
  output logic                              frame_start_o
);
  localparam int TW = $clog2(N_LAYERS+1);
  localparam int CW = $clog2(BLINK_DIV+1);
  logic [N_LAYERS*COLOR_W-1:0] col1_q;
  logic [N_LAYERS-1:0] vis1_q, vis1_d, en_sh_q, en_sh_d, bl_sh_q, bl_sh_d;
  logic act1_q, hs1_q, vs1_q, act2_q, hs2_q, vs2_q;
  logic [COLOR_W-1:0] color_q, color_d, sel_col;
  logic [TW-1:0] top_q, top_d, sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic phase_q, phase_d, fs_q, boundary, wrap;
  always_comb begin
    boundary = ~vsync_i & vs1_q;
    wrap = cnt_q == CW'(BLINK_DIV-1);
    for (int i = 0; i < N_LAYERS; i++)
      vis1_d[i] = (|layer_color_i[i*COLOR_W +: COLOR_W]) & en_sh_q[i] & ~(bl_sh_q[i] & phase_q);
    sel = TW'(N_LAYERS);
    sel_col = BG_COLOR;
    for (int i = N_LAYERS-1; i >= 0; i--)
      if (vis1_q[i]) begin
        sel = TW'(i);
        sel_col = col1_q[i*COLOR_W +: COLOR_W];
      end
    color_d = act1_q ? sel_col : '0;
    top_d = act1_q ? sel : TW'(N_LAYERS);
    en_sh_d = boundary ? layer_en_i : en_sh_q;
    bl_sh_d = boundary ? blink_en_i : bl_sh_q;
    cnt_d = boundary ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
    phase_d = phase_q ^ (boundary & wrap);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      col1_q <= '0;
      vis1_q <= '0;
      act1_q <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      color_q <= '0;
      top_q <= TW'(N_LAYERS);
      act2_q <= 1'b0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
      en_sh_q <= '1;
      bl_sh_q <= '0;
      cnt_q <= '0;
      phase_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      col1_q <= layer_color_i;
      vis1_q <= vis1_d;
      act1_q <= active_i;
      hs1_q <= hsync_i;
      vs1_q <= vsync_i;
      color_q <= color_d;
      top_q <= top_d;
      act2_q <= act1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      en_sh_q <= en_sh_d;
      bl_sh_q <= bl_sh_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      fs_q <= boundary;
    end
  end
  assign color_o = color_q;
  assign top_layer_o = top_q;
  assign active_o = act2_q;
  assign hsync_o = hs2_q;
  assign vsync_o = vs2_q;
  assign frame_start_o = fs_q;
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed and random checks against a frame-counting reference model
module tb_layer_compositor;
  localparam int N = 4, W = 3, DIV = 2;
  localparam logic [W-1:0] BG = 3'b001;
  logic clk = 1'b0, rst = 1'b0;
  logic [N*W-1:0] layer_color_i = '0;
  logic hsync_i = 1'b1, vsync_i = 1'b1, active_i = 1'b0;
  logic [N-1:0] layer_en_i = '1, blink_en_i = '0;
  logic [W-1:0] color_o;
  logic hsync_o, vsync_o, active_o, frame_start_o;
  logic [2:0] top_layer_o;
  layer_compositor #(.N_LAYERS(N), .COLOR_W(W), .BLINK_DIV(DIV), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .layer_color_i(layer_color_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .active_i(active_i), .layer_en_i(layer_en_i), .blink_en_i(blink_en_i), .color_o(color_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .active_o(active_o), .top_layer_o(top_layer_o),
    .frame_start_o(frame_start_o));
  always #5 clk = ~clk;
  typedef struct packed {logic [2:0] c; logic [2:0] t; logic a; logic h; logic v;} out_t;
  localparam out_t RST = '{c: 3'd0, t: 3'd4, a: 1'b0, h: 1'b1, v: 1'b1};
  out_t p1 = RST, exp_o = RST;
  logic exp_fs = 1'b0, prev_vs = 1'b1;
  logic [N-1:0] en_sh = '1, bl_sh = '0;
  int frames = 0, checks = 0, fails = 0;
  // blink phase follows directly from the number of frame boundaries since reset
  function automatic out_t ref_pixel();
    out_t o;
    logic phase;
    phase = ((frames / DIV) % 2) == 1;
    o = '{c: 3'd0, t: 3'd4, a: active_i, h: hsync_i, v: vsync_i};
    if (!active_i) return o;
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] c;
      c = layer_color_i[i*W +: W];
      if (c != 0 && en_sh[i] && !(bl_sh[i] && phase)) begin
        o.c = c;
        o.t = 3'(i);
        return o;
      end
    end
    o.c = BG;
    return o;
  endfunction
  task automatic cyc();
    @(posedge clk);
    if (!rst) begin
      exp_o = RST; p1 = RST; exp_fs = 1'b0; frames = 0;
      en_sh = '1; bl_sh = '0; prev_vs = 1'b1;
    end else begin
      exp_o = p1;
      p1 = ref_pixel();
      exp_fs = !vsync_i && prev_vs;
      if (exp_fs) begin
        en_sh = layer_en_i; bl_sh = blink_en_i; frames++;
      end
      prev_vs = vsync_i;
    end
    #1;
    checks += 6;
    assert (color_o === exp_o.c) else begin fails++; $error("FAIL color obs=%0h exp=%0h", color_o, exp_o.c); end
    assert (top_layer_o === exp_o.t) else begin fails++; $error("FAIL top obs=%0d exp=%0d", top_layer_o, exp_o.t); end
    assert (active_o === exp_o.a) else begin fails++; $error("FAIL active obs=%0b exp=%0b", active_o, exp_o.a); end
    assert (hsync_o === exp_o.h) else begin fails++; $error("FAIL hsync obs=%0b exp=%0b", hsync_o, exp_o.h); end
    assert (vsync_o === exp_o.v) else begin fails++; $error("FAIL vsync obs=%0b exp=%0b", vsync_o, exp_o.v); end
    assert (frame_start_o === exp_fs) else begin fails++; $error("FAIL frame_start obs=%0b exp=%0b", frame_start_o, exp_fs); end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin fails++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp); end
  endtask
  task automatic frame(input int low);
    vsync_i = 1'b0;
    repeat (low) cyc();
    vsync_i = 1'b1;
    repeat (30) cyc();
  endtask
  initial begin
    hsync_i = 1'b0;
    repeat (3) cyc();
    chk("rst_color", 32'(color_o), 0);
    chk("rst_top", 32'(top_layer_o), 4);
    chk("rst_hsync", 32'(hsync_o), 1);
    chk("rst_vsync", 32'(vsync_o), 1);
    chk("rst_fs", 32'(frame_start_o), 0);
    rst = 1'b1; hsync_i = 1'b1; active_i = 1'b1;
    layer_color_i = {3'b111, 3'b010, 3'b100, 3'b000};
    repeat (2) cyc();
    chk("t1_color", 32'(color_o), 3'b100);
    chk("t1_top", 32'(top_layer_o), 1);
    layer_color_i[2:0] = 3'b001;
    cyc();
    chk("t1_hold", 32'(color_o), 3'b100);
    cyc();
    chk("t1_l0_color", 32'(color_o), 3'b001);
    chk("t1_l0_top", 32'(top_layer_o), 0);
    layer_color_i = '0;
    repeat (2) cyc();
    chk("t2_bg_color", 32'(color_o), BG);
    chk("t2_bg_top", 32'(top_layer_o), 4);
    active_i = 1'b0; layer_color_i = {3'b000, 3'b000, 3'b110, 3'b000};
    repeat (2) cyc();
    chk("t2_blank_color", 32'(color_o), 0);
    chk("t2_blank_active", 32'(active_o), 0);
    active_i = 1'b1; hsync_i = 1'b0;
    repeat (96) cyc();
    hsync_i = 1'b1;
    repeat (20) cyc();
    layer_color_i = {3'b000, 3'b000, 3'b010, 3'b100}; layer_en_i = 4'b1110;
    repeat (5) cyc();
    chk("t4_pre", 32'(color_o), 3'b100);
    vsync_i = 1'b0;
    cyc();
    chk("t4_fs", 32'(frame_start_o), 1);
    chk("t4_edge_color", 32'(color_o), 3'b100);
    cyc();
    chk("t4_fs_once", 32'(frame_start_o), 0);
    chk("t4_old_shadow", 32'(color_o), 3'b100);
    cyc();
    chk("t4_new_color", 32'(color_o), 3'b010);
    chk("t4_new_top", 32'(top_layer_o), 1);
    repeat (5) cyc();
    vsync_i = 1'b1;
    repeat (20) cyc();
    layer_en_i = 4'b1111; blink_en_i = 4'b0001;
    frame(3);
    layer_en_i = 4'b0000; blink_en_i = 4'b0000;
    for (int f = 0; f < 6; f++) frame(f == 2 ? 500 : 4);
    layer_en_i = 4'b1111; blink_en_i = 4'b0001;
    frame(2);
    while (((frames / DIV) % 2) != 1) frame(2);
    repeat (3) cyc();
    chk("t6_pre_phase", 32'(color_o), 3'b010);
    rst = 1'b0;
    cyc();
    chk("t6_rst_color", 32'(color_o), 0);
    chk("t6_rst_top", 32'(top_layer_o), 4);
    rst = 1'b1;
    repeat (2) cyc();
    chk("t6_resume_color", 32'(color_o), 3'b100);
    chk("t6_resume_top", 32'(top_layer_o), 0);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        layer_color_i[i*W +: W] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      active_i = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) hsync_i = ~hsync_i;
      if ($urandom_range(0, 29) == 0) vsync_i = ~vsync_i;
      layer_en_i = 4'($urandom);
      blink_en_i = 4'($urandom);
      rst = $urandom_range(0, 299) != 0;
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined N-layer pixel compositor.
- Sits between the sprite/text/grid renderers and the VGA pin outputs.
- Replaces the fixed three-way combinational colour priority with a registered priority mux of fixed latency.
- Adds per-layer enable masks and per-layer blink, both double-buffered on frame boundaries, plus sync/blank delay matching.

Parameters:
- N_LAYERS, 4: number of input layers; layer 0 has the highest priority.
- COLOR_W, 3: bits per pixel colour ({R,G,B} for the 3-bit case).
- BLINK_DIV, 30: frames per blink half-period; legal range ≥1.
- BG_COLOR, 0: colour output when no layer is visible during active video.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-low (reset when rst==0 at a clk rising edge).
- layer_color_i  in  N_LAYERS*COLOR_W  layer i colour at bits [i*COLOR_W +: COLOR_W].
- hsync_i  in  1  horizontal sync from the VGA timing generator (active-low pulse).
- vsync_i  in  1  vertical sync (active-low pulse).
- active_i  in  1  1 = visible pixel region.
- layer_en_i  in  N_LAYERS  requested layer enable mask.
- blink_en_i  in  N_LAYERS  requested per-layer blink mask.
- color_o  out  COLOR_W  composited pixel colour.
- hsync_o  out  1  hsync_i delayed by 2 cycles.
- vsync_o  out  1  vsync_i delayed by 2 cycles.
- active_o  out  1  active_i delayed by 2 cycles.
- top_layer_o  out  $clog2(N_LAYERS+1)  index of the winning layer; N_LAYERS means background or blank.
- frame_start_o  out  1  one-cycle pulse on each detected frame boundary.

Behaviour:
- Reset values (rst==0):
  - color_o=0, top_layer_o=N_LAYERS, active_o=0, frame_start_o=0.
  - hsync_o=1, vsync_o=1; all sync delay stages reset to 1.
  - en_shadow=all ones, blink_shadow=0.
  - blink_cnt=0, blink_phase=0, vsync_q=1.
- Reset mid-frame takes effect at the next edge. Pipeline contents are discarded and outputs show reset values for the whole time rst==0.
- Transparency: a layer whose colour equals 0 is transparent.
- visible[i] = (color_i != 0) & en_shadow[i] & ~(blink_shadow[i] & blink_phase).
- Pipeline: fixed latency of 2 cycles for every output except frame_start_o.
  - Stage 1 registers the colours, the visible vector and active/hsync/vsync.
  - Stage 2 registers the priority-select result and the delayed syncs.
  - Inputs sampled at edge k appear on outputs after edge k+2.
  - There are no bubbles and no stalls; a new pixel is accepted every cycle.
- Priority select: the lowest index i with visible[i] wins. color_o = colour of layer i, top_layer_o = i.
- No visible layer: color_o=BG_COLOR, top_layer_o=N_LAYERS.
- Blanking: stage-1 active=0 forces color_o=0 and top_layer_o=N_LAYERS, regardless of layers or BG_COLOR.
- Frame boundary: vsync_i==0 while vsync_q==1 (falling edge of vsync, detected on the registered copy). At the edge where this holds:
  - en_shadow<=layer_en_i and blink_shadow<=blink_en_i.
  - If blink_cnt==BLINK_DIV-1: blink_cnt<=0 and blink_phase toggles. Otherwise blink_cnt increments.
  - frame_start_o=1 for exactly the following cycle.
- Shadow timing:
  - The pixel sampled at the boundary edge is evaluated with the old shadows and old phase.
  - The new values apply from the next sampled pixel.
  - layer_en_i and blink_en_i changes between boundaries have no effect on the output.
- Simultaneous boundary and reset: reset wins.
- vsync held low for many cycles produces a single boundary event.
- BLINK_DIV=1: the phase toggles every frame.
- A layer with both enable=0 and blink=1 stays hidden in both phases.
- Arithmetic:
  - blink_cnt width is $clog2(BLINK_DIV+1).
  - The colour compare is a full COLOR_W-bit compare against zero.
  - The select is pure priority with no blending.

Test Plan:
1. Priority and latency:
   - Stimulus: reset, then active_i=1, layers {L0=0, L1=3'b100, L2=3'b010, L3=3'b111}, all enabled.
   - Required: two cycles later color_o=3'b100, top_layer_o=1. Then set L0=3'b001 → color_o=3'b001, top_layer_o=0 exactly 2 cycles later.
2. Background and blanking:
   - Stimulus A: all layers 0, BG_COLOR=3'b001, active_i=1. Required: color_o=3'b001, top_layer_o=4.
   - Stimulus B: drop active_i to 0 with L1=3'b110. Required: color_o=0 and active_o=0 two cycles later.
3. Sync alignment:
   - Stimulus: drive an hsync_i/vsync_i pattern, e.g. hsync low for 96 cycles.
   - Required: hsync_o/vsync_o are bit-identical to the inputs shifted by 2 cycles; after reset they are 1.
4. Enable double-buffering:
   - Stimulus: mid-frame set layer_en_i=4'b1110 with L0=3'b100, L1=3'b010.
   - Required: output stays 3'b100 until the vsync falling edge. frame_start_o pulses once. The first post-boundary pixel shows 3'b010, top_layer_o=1.
5. Blink:
   - Stimulus: BLINK_DIV=2, blink_en_i=4'b0001 latched at a boundary, L0=3'b100, L1=3'b010.
   - Required: output alternates 3'b100 for 2 frames, 3'b010 for 2 frames, repeating.
   - Also: holding vsync low for 500 cycles counts as one frame.
6. Reset mid-operation:
   - Stimulus: assert rst=0 for 1 cycle during active video with a blink phase of 1.
   - Required: next cycle outputs are at reset values; blink_phase=0; en_shadow=all ones; compositing resumes with 2-cycle latency after rst=1.
